// File: rtl/spram_rd_pkg.sv
// Shared types and constants for the single-port RAM stream reader.
package spram_rd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      CLEAR = 2'd2,
      DRAIN = 2'd3
   } state_t;

   localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/spram_rd_skid.sv
// Two-entry FIFO that absorbs RAM read data while the stream sink stalls.
// Head entry drives the outputs directly, so they hold stable until popped.
module spram_rd_skid #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          push_last,
   input  logic          pop,
   output logic [1:0]    count,
   output logic [DW-1:0] data,
   output logic          last
);

   logic [DW-1:0] tail_data;
   logic          tail_last;
   logic          head_last;
   logic          pop_ok;

   assign pop_ok = pop && (count != 2'd0);
   assign last   = head_last && (count != 2'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count     <= 2'd0;
         data      <= '0;
         head_last <= 1'b0;
         tail_data <= '0;
         tail_last <= 1'b0;
      end else begin
         case ({push, pop_ok})
            2'b10: begin
               if (count == 2'd0) begin
                  data      <= push_data;
                  head_last <= push_last;
               end else begin
                  tail_data <= push_data;
                  tail_last <= push_last;
               end
               count <= count + 2'd1;
            end
            2'b01: begin
               data      <= tail_data;
               head_last <= tail_last;
               count     <= count - 2'd1;
            end
            2'b11: begin
               // Occupancy unchanged: new word lands behind whatever remains.
               if (count == 2'd1) begin
                  data      <= push_data;
                  head_last <= push_last;
               end else begin
                  data      <= tail_data;
                  head_last <= tail_last;
                  tail_data <= push_data;
                  tail_last <= push_last;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/spram_stream_reader.sv
// Streams a burst of words out of a single-port RAM, optionally zeroing each word
// after it is read (enabled by macro SPRAM_READER_CLEAR_EN).
module spram_stream_reader
   import spram_rd_pkg::*;
#(
   parameter int AW = 10,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic [AW-1:0] len_m1,
   input  logic          clr_en,
   output logic          busy,
   output logic          done,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_d,
   input  logic [DW-1:0] ram_q,
   output logic          m_valid,
   output logic [DW-1:0] m_data,
   output logic          m_last,
   input  logic          m_ready
);

   state_t        state, state_nxt;
   logic [AW-1:0] rd_addr;
   logic [AW-1:0] prev_addr;
   logic [AW-1:0] rem;
   logic          issued_all;
   logic          issue;
   logic          rd_vld_p1;
   logic          rd_last_p1;
   logic          pop;
   logic          room;
   logic [1:0]    fifo_count;
   logic [2:0]    occ_sum;
   logic          clr_q;

   assign pop     = m_valid && m_ready;
   assign m_valid = (fifo_count != 2'd0);
   assign busy    = (state != IDLE);
   // Reads in flight count against FIFO space so the RAM never overruns the buffer.
   assign occ_sum = {1'b0, fifo_count} + {2'b00, rd_vld_p1} - {2'b00, pop};
   assign room    = (occ_sum < 3'(FIFO_DEPTH));

   assign ram_addr = (state == CLEAR) ? prev_addr : rd_addr;
   assign ram_d    = '0;

`ifdef SPRAM_READER_CLEAR_EN
   assign ram_we = (state == CLEAR);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         clr_q <= 1'b0;
      else if (state == IDLE && start)
         clr_q <= clr_en;
   end
`else
   logic clr_unused;
   assign clr_unused = clr_en;
   assign clr_q      = 1'b0;
   assign ram_we     = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = READ;
         READ: begin
            if (room) begin
               issue = 1'b1;
               if (clr_q)
                  state_nxt = CLEAR;
               else if (rem == '0)
                  state_nxt = DRAIN;
            end
         end
         CLEAR: state_nxt = issued_all ? DRAIN : READ;
         DRAIN: if (pop && m_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         rd_addr    <= '0;
         prev_addr  <= '0;
         rem        <= '0;
         issued_all <= 1'b0;
         rd_vld_p1  <= 1'b0;
         rd_last_p1 <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nxt;
         rd_vld_p1  <= issue;
         rd_last_p1 <= issue && (rem == '0);
         done       <= (state == DRAIN) && pop && m_last;
         if (state == IDLE && start) begin
            rd_addr    <= base_addr;
            rem        <= len_m1;
            issued_all <= 1'b0;
         end else if (issue) begin
            // rem counts down to zero, so a full 2^AW sweep wraps addresses without stopping early.
            prev_addr <= rd_addr;
            rd_addr   <= rd_addr + AW'(1);
            if (rem == '0)
               issued_all <= 1'b1;
            else
               rem <= rem - AW'(1);
         end
      end
   end

   // ---- stage p1: RAM data returns and is captured into the FIFO ----
   spram_rd_skid #(.DW(DW)) u_skid (
      .clk       (clk),
      .reset     (reset),
      .push      (rd_vld_p1),
      .push_data (ram_q),
      .push_last (rd_last_p1),
      .pop       (pop),
      .count     (fifo_count),
      .data      (m_data),
      .last      (m_last)
   );

endmodule

// File: tb/tb_spram_stream_reader.sv
// Scoreboard bench for spram_stream_reader with a behavioural RAM and reference model.
module tb_spram_stream_reader;

   localparam int AW = 4;
   localparam int DW = 8;
   localparam int N  = 16;
`ifdef SPRAM_READER_CLEAR_EN
   localparam bit CLR_BUILD = 1'b1;
`else
   localparam bit CLR_BUILD = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW-1:0] len_m1 = '0;
   logic          clr_en = 1'b0;
   logic          busy, done, ram_we, m_valid, m_last;
   logic          m_ready;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_d, ram_q, m_data;

   always #5 clk = ~clk;

   spram_stream_reader #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .len_m1(len_m1), .clr_en(clr_en), .busy(busy), .done(done),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_d(ram_d), .ram_q(ram_q),
      .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
   );

   // Behavioural synchronous RAM with a bulk preload port.
   logic [DW-1:0] mem    [N];
   logic [DW-1:0] ld_mem [N];
   logic [DW-1:0] ref_mem[N];
   logic          load_req = 1'b0;

   always @(posedge clk) begin
      if (load_req)
         for (int i = 0; i < N; i++) mem[i] <= ld_mem[i];
      else if (ram_we)
         mem[ram_addr] <= ram_d;
      ram_q <= mem[ram_addr];
   end

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   logic [DW:0] sb_q[$];
   int rdy_mode = 0;
   int we_cnt = 0;
   int first_cyc = 0;
   int last_cyc = 0;
   bit want_first = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Sink ready patterns: always ready, 1-0-0 repeating, random.
   initial begin
      int pat = 0;
      m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = (pat % 3 == 0);
            default: m_ready = 1'($urandom_range(0, 1));
         endcase
         pat++;
      end
   end

   // Monitor: pops expected words, checks stall stability, done timing and clear writes.
   initial begin
      bit          stall_pend = 1'b0;
      bit          last_prev = 1'b0;
      logic [DW:0] held = '0;
      logic [DW:0] exp_w;
      logic [AW-1:0] addr_prev = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            stall_pend = 1'b0;
            last_prev  = 1'b0;
         end else begin
            check_eq("done_pulse", done, last_prev);
            if (last_prev) check_eq("busy_fall", busy, 0);
            if (stall_pend) begin
               check_eq("stall_valid", m_valid, 1);
               check_eq("stall_hold", {m_last, m_data}, held);
            end
            stall_pend = m_valid && !m_ready;
            held = {m_last, m_data};
            if (m_valid && m_ready) begin
               if (sb_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL unexpected_word: got 0x%0h, expected no word", {m_last, m_data});
               end else begin
                  exp_w = sb_q.pop_front();
                  check_eq("word", {m_last, m_data}, exp_w);
               end
               if (want_first) begin
                  first_cyc  = cyc;
                  want_first = 1'b0;
               end
               if (m_last) last_cyc = cyc;
            end
            last_prev = m_valid && m_ready && m_last;
            if (ram_we) begin
               we_cnt++;
               check_eq("clear_data", ram_d, 0);
               check_eq("clear_addr", ram_addr, addr_prev);
            end
            addr_prev = ram_addr;
         end
      end
   end

   task automatic preload(input bit incr);
      for (int i = 0; i < N; i++) begin
         ld_mem[i]  = incr ? DW'(i + 'h10) : DW'($urandom);
         ref_mem[i] = ld_mem[i];
      end
      load_req = 1'b1;
      @(posedge clk);
      #1;
      load_req = 1'b0;
   endtask

   // Reference: expected words come straight from the address rule and the memory image.
   task automatic issue_start(input logic [AW-1:0] b, input logic [AW-1:0] l, input logic c);
      logic [AW-1:0] a;
      for (int i = 0; i <= int'(l); i++) begin
         a = AW'(int'(b) + i);
         sb_q.push_back({(i == int'(l)), ref_mem[a]});
      end
      if (c && CLR_BUILD)
         for (int i = 0; i <= int'(l); i++) ref_mem[AW'(int'(b) + i)] = '0;
      want_first = 1'b1;
      we_cnt = 0;
      start = 1'b1;
      base_addr = b;
      len_m1 = l;
      clr_en = c;
      @(posedge clk);
      #1;
      start = 1'b0;
      base_addr = AW'($urandom);
      len_m1 = AW'($urandom);
      clr_en = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_done(input string name);
      bit seen = 1'b0;
      int bad = 0;
      for (int k = 0; k < 3000 && !seen; k++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      n_checks++;
      if (!seen) begin
         n_errors++;
         $display("FAIL %s_timeout: got done=0, expected done=1 within 3000 cycles", name);
      end
      @(posedge clk);
      #1;
      check_eq({name, "_sb_empty"}, sb_q.size(), 0);
      for (int i = 0; i < N; i++) if (mem[i] !== ref_mem[i]) bad++;
      check_eq({name, "_mem"}, bad, 0);
   endtask

   task automatic check_all_zero(input string name);
      check_eq({name, "_busy"}, busy, 0);
      check_eq({name, "_done"}, done, 0);
      check_eq({name, "_m_valid"}, m_valid, 0);
      check_eq({name, "_m_last"}, m_last, 0);
      check_eq({name, "_ram_we"}, ram_we, 0);
      check_eq({name, "_ram_addr"}, ram_addr, 0);
      check_eq({name, "_ram_d"}, ram_d, 0);
      check_eq({name, "_m_data"}, m_data, 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got no completion, expected finish before 30000 cycles");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [AW-1:0] rb, rl;
      logic          rc;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      reset = 1'b0;
      @(posedge clk);
      #1;
      check_eq("idle_busy", busy, 0);

      // Base 3, 4+1 words, full rate.
      preload(1'b1);
      rdy_mode = 0;
      issue_start(4'd3, 4'd4, 1'b0);
      check_eq("t1_busy", busy, 1);
      @(posedge clk);
      #1;
      check_eq("t1_valid_c1", m_valid, 0);
      @(posedge clk);
      #1;
      check_eq("t1_valid_c2", m_valid, 1);
      check_eq("t1_first_data", m_data, 'h13);
      wait_done("t1");
      check_eq("t1_span", last_cyc - first_cyc, 4);

      // Wrap past the top of memory.
      issue_start(4'd14, 4'd3, 1'b0);
      wait_done("t2");
      check_eq("t2_span", last_cyc - first_cyc, 3);

      // Stalling sink.
      rdy_mode = 1;
      issue_start(4'd5, 4'd9, 1'b0);
      wait_done("t3");

      // Clear after read.
      rdy_mode = 0;
      issue_start(4'd0, 4'd2, 1'b1);
      wait_done("t4");
      check_eq("t4_we_count", we_cnt, CLR_BUILD ? 3 : 0);
      check_eq("t4_span", last_cyc - first_cyc, CLR_BUILD ? 4 : 2);

      // Reset three cycles into a 16-word burst.
      preload(1'b1);
      issue_start(4'd0, 4'd15, 1'b0);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b1;
      sb_q.delete();
      #1;
      check_all_zero("midreset");
      @(posedge clk);
      #1;
      reset = 1'b0;
      issue_start(4'd7, 4'd5, 1'b0);
      wait_done("t5");

      // Start while busy must be ignored.
      issue_start(4'd2, 4'd6, 1'b0);
      @(posedge clk);
      #1;
      start = 1'b1;
      base_addr = 4'd9;
      len_m1 = 4'd1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done("t6");

      // Full-memory sweep starting mid-array.
      preload(1'b0);
      rdy_mode = 2;
      issue_start(4'd9, 4'd15, 1'b0);
      wait_done("t7");

      // Randomized bursts.
      for (int it = 0; it < 30; it++) begin
         preload(1'b0);
         rdy_mode = $urandom_range(0, 2);
         rb = AW'($urandom);
         rl = ($urandom_range(0, 4) == 0) ? 4'd15 : AW'($urandom);
         rc = 1'($urandom_range(0, 1));
         issue_start(rb, rl, rc);
         wait_done("rand");
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
